sim_exit_monitor: RTL and testbench

- Synthesizable run-control monitor placed beside the top-level CPU, on the data-memory store bus (MemWrite/DataAdr/WriteData) and the program counter.
- Detects program termination by one of four causes, latched sticky:
  - a store of the pass value to the exit address;
  - a store of any other value to the exit address;
  - a cycle-budget timeout;
  - a PC self-loop stall.
- Also forwards byte stores to a console address.
- Benches and FPGA builds read its status outputs instead of hard-coding the termination check in each testbench.

---
 rtl/sim_monitor_pkg.sv | 24 ++
 rtl/sat_counter.sv | 30 +++
 rtl/sim_exit_monitor.sv | 187 ++++++++++++++++++
 tb/tb_sim_exit_monitor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_monitor_pkg.sv
// sim_monitor_pkg: shared termination-cause encoding and default monitor
// addresses for sim_exit_monitor and its helpers.
package sim_monitor_pkg;

  typedef logic [2:0] cause_t;

  // Termination cause encoding; RUN is the only non-absorbing state.
  localparam cause_t CAUSE_RUN     = 3'd0;
  localparam cause_t CAUSE_PASS    = 3'd1;
  localparam cause_t CAUSE_FAIL    = 3'd2;
  localparam cause_t CAUSE_TIMEOUT = 3'd3;
  localparam cause_t CAUSE_STALL   = 3'd4;

  // Default memory map of the run-control locations.
  localparam logic [31:0] DEFAULT_EXIT_ADDR    = 32'h0200_0004;
  localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0200_0000;
  localparam logic [31:0] DEFAULT_PASS_VALUE   = 32'd5;

  // True once the monitor has left RUN.
  function automatic logic is_terminal(input cause_t c);
    return (c != CAUSE_RUN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with enable and synchronous clear that sticks at
// all-ones instead of wrapping. Clear has priority over enable.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Count on enable, hold at the maximum value, clear synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en && (r_q != {W{1'b1}})) begin
      r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sim_exit_monitor.sv
// sim_exit_monitor: watches the CPU store bus and PC, latches the first
// termination cause (exit store pass/fail, cycle timeout, PC stall) and
// forwards console byte stores.
// Optional build macro: SIM_EXIT_MONITOR_TRACE_EN (simulation-only tracing of
// console characters and the termination report).
module sim_exit_monitor
  import sim_monitor_pkg::*;
#(
  parameter int             AW           = 32,
  parameter int             DW           = 32,
  parameter logic [AW-1:0]  EXIT_ADDR    = AW'(DEFAULT_EXIT_ADDR),
  parameter logic [DW-1:0]  PASS_VALUE   = DW'(DEFAULT_PASS_VALUE),
  parameter logic [AW-1:0]  CONSOLE_ADDR = AW'(DEFAULT_CONSOLE_ADDR),
  parameter int             MAX_CYCLES   = 10000,
  parameter int             STALL_CYCLES = 64,
  parameter int             CW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [AW-1:0] DataAdr,
  input  logic [DW-1:0] WriteData,
  input  logic [AW-1:0] ProgramCounter,
  output logic          done,
  output logic          pass,
  output logic [2:0]    cause,
  output logic [DW-1:0] exit_code,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] store_count,
  output logic          console_valid,
  output logic [7:0]    console_char
);

  // Counter values that trigger the timeout and stall transitions.
  localparam logic [CW-1:0] TIMEOUT_AT = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] STALL_AT   = CW'(STALL_CYCLES - 1);
  localparam logic          STALL_EN   = (STALL_CYCLES != 0);

  cause_t        r_cause;
  logic          r_done;
  logic          r_pass;
  logic [DW-1:0] r_exit_code;
  logic [AW-1:0] r_last_pc;
  logic          r_console_valid;
  logic [7:0]    r_console_char;

  logic [CW-1:0] w_cycle_count;
  logic [CW-1:0] w_store_count;
  logic [CW-1:0] w_stall_count;
  logic          w_run;
  logic          w_store;
  logic          w_exit;
  logic          w_console;
  logic          w_pc_same;
  logic          w_timeout;
  logic          w_stall;
  cause_t        w_next_cause;

  assign w_run     = !is_terminal(r_cause);
  assign w_store   = w_run && MemWrite;
  assign w_exit    = w_store && (DataAdr == EXIT_ADDR);
  assign w_console = w_store && (DataAdr == CONSOLE_ADDR);
  assign w_pc_same = (ProgramCounter == r_last_pc);
  assign w_timeout = w_run && (w_cycle_count == TIMEOUT_AT);
  assign w_stall   = w_run && STALL_EN && w_pc_same && (w_stall_count == STALL_AT);

  // Cycles since reset release; stops advancing once terminated.
  sat_counter #(.W(CW)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (1'b0),
    .i_en  (w_run),
    .o_q   (w_cycle_count)
  );

  // Every store seen while running, including the terminating exit store.
  sat_counter #(.W(CW)) u_store_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (1'b0),
    .i_en  (w_store),
    .o_q   (w_store_count)
  );

  // Length of the current run of cycles with an unchanged PC.
  sat_counter #(.W(CW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_run && !w_pc_same),
    .i_en  (w_run && w_pc_same),
    .o_q   (w_stall_count)
  );

  // Next termination state: exit store beats timeout, timeout beats stall.
  always_comb begin
    w_next_cause = r_cause;
    if (w_exit) begin
      w_next_cause = (WriteData == PASS_VALUE) ? CAUSE_PASS : CAUSE_FAIL;
    end else if (w_timeout) begin
      w_next_cause = CAUSE_TIMEOUT;
    end else if (w_stall) begin
      w_next_cause = CAUSE_STALL;
    end else begin
      w_next_cause = r_cause;
    end
  end

  // Status, exit code and PC history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cause     <= CAUSE_RUN;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_exit_code <= '0;
      r_last_pc   <= '0;
    end else begin
      r_cause   <= w_next_cause;
      r_done    <= is_terminal(w_next_cause);
      r_pass    <= (w_next_cause == CAUSE_PASS);
      r_last_pc <= ProgramCounter;
      if (w_exit) begin
        r_exit_code <= WriteData;
      end else begin
        r_exit_code <= r_exit_code;
      end
    end
  end

  // Console byte capture with a one-cycle valid pulse per store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_console_valid <= 1'b0;
      r_console_char  <= 8'h00;
    end else begin
      r_console_valid <= w_console;
      if (w_console) begin
        r_console_char <= WriteData[7:0];
      end else begin
        r_console_char <= r_console_char;
      end
    end
  end

  assign done          = r_done;
  assign pass          = r_pass;
  assign cause         = r_cause;
  assign exit_code     = r_exit_code;
  assign cycle_count   = w_cycle_count;
  assign store_count   = w_store_count;
  assign console_valid = r_console_valid;
  assign console_char  = r_console_char;

`ifdef SIM_EXIT_MONITOR_TRACE_EN
  logic r_done_d;

  function automatic string cause_name(input cause_t c);
    case (c)
      CAUSE_RUN:     return "RUN";
      CAUSE_PASS:    return "PASS";
      CAUSE_FAIL:    return "FAIL";
      CAUSE_TIMEOUT: return "TIMEOUT";
      CAUSE_STALL:   return "STALL";
      default:       return "UNKNOWN";
    endcase
  endfunction

  // Echo console characters and report the termination once, then stop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done_d <= 1'b0;
    end else begin
      r_done_d <= r_done;
      if (r_console_valid) begin
        $write("%c", r_console_char);
      end
      if (r_done && !r_done_d) begin
        $display("[sim_exit_monitor] cause=%s exit_code=%0d cycle_count=%0d",
                 cause_name(r_cause), r_exit_code, w_cycle_count);
        $finish;
      end
    end
  end
`else
  // Untraced build: termination status is visible only on the ports.
`endif

endmodule

// File: tb/tb_sim_exit_monitor.sv
// tb_sim_exit_monitor: two monitor instances on one shared stimulus bus
// (long budget with stall detection, short budget without), checked
// against a cycle-level reference model plus directed vector tables.
module tb_sim_exit_monitor;
  import sim_monitor_pkg::*;

  localparam logic [31:0] EXIT_A  = 32'h0200_0004;
  localparam logic [31:0] CONS_A  = 32'h0200_0000;
  localparam int          MAX_A   = 1000;
  localparam int          STALL_A = 8;
  localparam int          MAX_B   = 50;
  localparam int          STALL_B = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ProgramCounter = 32'h0;

  logic        done_a, pass_a, cv_a, done_b, pass_b, cv_b;
  logic [2:0]  cause_a, cause_b;
  logic [31:0] exit_a, cyc_a, sc_a, exit_b, cyc_b, sc_b;
  logic [7:0]  cc_a, cc_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sim_exit_monitor #(.MAX_CYCLES(MAX_A), .STALL_CYCLES(STALL_A)) u_dut_a (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ProgramCounter(ProgramCounter),
    .done(done_a), .pass(pass_a), .cause(cause_a), .exit_code(exit_a),
    .cycle_count(cyc_a), .store_count(sc_a),
    .console_valid(cv_a), .console_char(cc_a)
  );

  sim_exit_monitor #(.MAX_CYCLES(MAX_B), .STALL_CYCLES(STALL_B)) u_dut_b (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ProgramCounter(ProgramCounter),
    .done(done_b), .pass(pass_b), .cause(cause_b), .exit_code(exit_b),
    .cycle_count(cyc_b), .store_count(sc_b),
    .console_valid(cv_b), .console_char(cc_b)
  );

  // Reference model state: counts and the length of the equal-PC run.
  typedef struct packed {
    logic        done;
    logic [2:0]  cause;
    logic [31:0] exit_code;
    logic [31:0] cycles;
    logic [31:0] stores;
    logic [31:0] eq_run;
    logic [31:0] prev_pc;
    logic        cv;
    logic [7:0]  cc;
  } model_t;

  typedef struct packed {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        e_done;
    logic        e_pass;
    logic [2:0]  e_cause;
    logic [31:0] e_exit;
    logic [31:0] e_cyc;
    logic [31:0] e_sc;
    logic        e_cv;
    logic [7:0]  e_cc;
  } vec_t;

  model_t m_a, m_b;
  vec_t   vecs [10];

  function automatic model_t step(model_t m, int max_c, int stall_c, logic mw,
                                  logic [31:0] adr, logic [31:0] wd, logic [31:0] pc);
    model_t n = m;
    n.cv = 1'b0;
    n.prev_pc = pc;
    if (!m.done) begin
      n.eq_run = (pc == m.prev_pc) ? m.eq_run + 32'd1 : 32'd0;
      if (m.cycles != 32'hFFFF_FFFF) n.cycles = m.cycles + 32'd1;
      if (mw) begin
        if (m.stores != 32'hFFFF_FFFF) n.stores = m.stores + 32'd1;
        if (adr == CONS_A) begin
          n.cv = 1'b1;
          n.cc = wd[7:0];
        end
      end
      if (mw && adr == EXIT_A) begin
        n.done = 1'b1;
        n.cause = (wd == 32'd5) ? 3'd1 : 3'd2;
        n.exit_code = wd;
      end else if (n.cycles == 32'(max_c)) begin
        n.done = 1'b1;
        n.cause = 3'd3;
      end else if (stall_c != 0 && n.eq_run == 32'(stall_c)) begin
        n.done = 1'b1;
        n.cause = 3'd4;
      end
    end
    return n;
  endfunction

  function automatic logic [109:0] pk_a();
    return {done_a, pass_a, cause_a, exit_a, cyc_a, sc_a, cv_a, cc_a};
  endfunction

  function automatic logic [109:0] pk_b();
    return {done_b, pass_b, cause_b, exit_b, cyc_b, sc_b, cv_b, cc_b};
  endfunction

  function automatic logic [109:0] pk_m(model_t m);
    return {m.done, m.done && (m.cause == 3'd1), m.cause, m.exit_code,
            m.cycles, m.stores, m.cv, m.cc};
  endfunction

  function automatic vec_t mk(logic mw, logic [31:0] adr, logic [31:0] wd, logic [31:0] pc,
                              logic ed, logic ep, logic [2:0] ec, logic [31:0] ee,
                              logic [31:0] ecy, logic [31:0] es, logic ev, logic [7:0] ech);
    vec_t v;
    v.mw = mw; v.adr = adr; v.wd = wd; v.pc = pc;
    v.e_done = ed; v.e_pass = ep; v.e_cause = ec; v.e_exit = ee;
    v.e_cyc = ecy; v.e_sc = es; v.e_cv = ev; v.e_cc = ech;
    return v;
  endfunction

  task automatic check_vec(string name, logic [109:0] act, logic [109:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_eq(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic mw, logic [31:0] adr, logic [31:0] wd, logic [31:0] pc);
    MemWrite = mw;
    DataAdr = adr;
    WriteData = wd;
    ProgramCounter = pc;
  endtask

  // One clock edge: advance both models, then compare both DUTs to them.
  task automatic tick();
    @(posedge clk);
    m_a = step(m_a, MAX_A, STALL_A, MemWrite, DataAdr, WriteData, ProgramCounter);
    m_b = step(m_b, MAX_B, STALL_B, MemWrite, DataAdr, WriteData, ProgramCounter);
    #1;
    check_vec("model_a", pk_a(), pk_m(m_a));
    check_vec("model_b", pk_b(), pk_m(m_b));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    m_a = '0;
    m_b = '0;
    @(posedge clk);
    #1;
    check_vec("reset_a", pk_a(), 110'b0);
    check_vec("reset_b", pk_b(), 110'b0);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    int          hold_pct;
    int          sel;

    vecs[0] = mk(1'b1, CONS_A, 32'h48, 32'd4,  1'b0, 1'b0, 3'd0, 32'd0, 32'd1, 32'd1, 1'b1, 8'h48);
    vecs[1] = mk(1'b1, CONS_A, 32'h69, 32'd8,  1'b0, 1'b0, 3'd0, 32'd0, 32'd2, 32'd2, 1'b1, 8'h69);
    vecs[2] = mk(1'b0, CONS_A, 32'h21, 32'd12, 1'b0, 1'b0, 3'd0, 32'd0, 32'd3, 32'd2, 1'b0, 8'h69);
    vecs[3] = mk(1'b1, 32'h0200_0001, 32'h41, 32'd16, 1'b0, 1'b0, 3'd0, 32'd0, 32'd4, 32'd3, 1'b0, 8'h69);
    vecs[4] = mk(1'b0, EXIT_A, 32'd5, 32'd20, 1'b0, 1'b0, 3'd0, 32'd0, 32'd5, 32'd3, 1'b0, 8'h69);
    vecs[5] = mk(1'b1, 32'h8200_0004, 32'd5, 32'd24, 1'b0, 1'b0, 3'd0, 32'd0, 32'd6, 32'd4, 1'b0, 8'h69);
    vecs[6] = mk(1'b1, EXIT_A, 32'd7, 32'd28, 1'b1, 1'b0, 3'd2, 32'd7, 32'd7, 32'd5, 1'b0, 8'h69);
    vecs[7] = mk(1'b1, EXIT_A, 32'd5, 32'd32, 1'b1, 1'b0, 3'd2, 32'd7, 32'd7, 32'd5, 1'b0, 8'h69);
    vecs[8] = mk(1'b1, CONS_A, 32'h5A, 32'd36, 1'b1, 1'b0, 3'd2, 32'd7, 32'd7, 32'd5, 1'b0, 8'h69);
    vecs[9] = mk(1'b0, 32'h0, 32'h0, 32'd36, 1'b1, 1'b0, 3'd2, 32'd7, 32'd7, 32'd5, 1'b0, 8'h69);

    // Directed table: console bytes, near-miss addresses, fail then ignored pass.
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].mw, vecs[i].adr, vecs[i].wd, vecs[i].pc);
      tick();
      check_vec($sformatf("vec%0d", i), pk_a(),
                {vecs[i].e_done, vecs[i].e_pass, vecs[i].e_cause, vecs[i].e_exit,
                 vecs[i].e_cyc, vecs[i].e_sc, vecs[i].e_cv, vecs[i].e_cc});
    end

    // Pass store at cycle 100 on A; short-budget B times out at edge 50.
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 32'h0, 32'h0, 32'(4 * (i + 1)));
      tick();
      if (i == 48) check_eq("b_not_done_49", 32'(done_b), 32'd0);
      if (i == 49) begin
        check_eq("b_done_50", 32'(done_b), 32'd1);
        check_eq("b_cause_timeout", 32'(cause_b), 32'd3);
      end
    end
    check_eq("a_cyc_100", cyc_a, 32'd100);
    drive(1'b1, EXIT_A, 32'd5, 32'd404);
    tick();
    check_vec("a_pass_at_100", pk_a(),
              {1'b1, 1'b1, 3'd1, 32'd5, 32'd101, 32'd1, 1'b0, 8'h00});
    check_vec("b_timeout_frozen", pk_b(),
              {1'b1, 1'b0, 3'd3, 32'd0, 32'd50, 32'd0, 1'b0, 8'h00});
    drive(1'b0, 32'h0, 32'h0, 32'd408);
    tick();
    tick();
    check_eq("a_cyc_frozen", cyc_a, 32'd101);

    // PC held at 0x40: stall after the 8th equal cycle (edge 9) on A only.
    apply_reset();
    drive(1'b0, 32'h0, 32'h0, 32'h40);
    for (int i = 0; i < 8; i++) tick();
    check_eq("a_not_stalled_8", 32'(done_a), 32'd0);
    tick();
    check_eq("a_cause_stall", 32'(cause_a), 32'd4);
    check_eq("a_stall_exit0", exit_a, 32'd0);
    check_eq("b_no_stall", 32'(done_b), 32'd0);

    // Pass store on the same edge as the stall: pass wins.
    apply_reset();
    drive(1'b0, 32'h0, 32'h0, 32'h40);
    for (int i = 0; i < 8; i++) tick();
    drive(1'b1, EXIT_A, 32'd5, 32'h40);
    tick();
    check_eq("a_pass_beats_stall", 32'(cause_a), 32'd1);

    // Reset pulsed mid-run: outputs clear at once, counting restarts.
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      drive((i % 7) == 3, CONS_A, 32'(65 + i), 32'(8 * i + 4));
      tick();
    end
    check_eq("a_cyc_30", cyc_a, 32'd30);
    #2;
    reset = 1'b0;
    m_a = '0;
    m_b = '0;
    #1;
    check_vec("a_async_reset", pk_a(), 110'b0);
    check_vec("b_async_reset", pk_b(), 110'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 32'h0, 32'(4 * i + 4));
      tick();
    end
    check_eq("a_cyc_restart", cyc_a, 32'd3);

    // Randomized episodes against the model, with rising PC-hold rates.
    for (int ep = 0; ep < 6; ep++) begin
      apply_reset();
      pc = 32'h100;
      hold_pct = 50 + ep * 9;
      for (int c = 0; c < 160; c++) begin
        sel = int'($urandom_range(0, 99));
        if ($urandom_range(0, 99) >= hold_pct) pc = pc + 32'd4;
        drive($urandom_range(0, 2) == 0,
              (sel < 3) ? EXIT_A :
              (sel < 40) ? CONS_A :
              (sel < 50) ? (CONS_A ^ (32'h1 << $urandom_range(0, 31))) : $urandom,
              ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 9)) : $urandom,
              pc);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
